// File: rtl/mux81_rr_sched_pkg.sv
// Shared constants and types for the round-robin mux81 scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux81_rr_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux81.sv
// Existing shared 8:1 one-bit selector.
// Latency: combinational.
// Backpressure: none.
module mux81 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  // Plain index select.
  always_comb begin
    y = i[s];
  end

endmodule

// File: rtl/mux81_rr_sched_rr_pick8.sv
// Round-robin priority encoder: first set req bit after ptr, wrapping mod 8.
// Latency: combinational.
// Backpressure: none; any=0 when no bit is set.
module rr_pick8
  import mux81_rr_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Scan ptr+1 .. ptr+8; the last candidate is ptr itself, so it wins only when alone.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux81_rr_sched.sv
// Round-robin scheduler sharing one mux81 among 8 requesters, with bounded hold time.
// Latency: req sampled at edge t gives gnt/sel/valid after edge t; y is combinational from sel/d.
// Backpressure: requesters wait while another holds the grant; a hold ends on done, req drop or timeout.
module mux81_rr_sched
  import mux81_rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  input  logic [N_REQ-1:0] d,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             valid,
  output logic             y
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             release_now;
  logic             mux_y;

  // While busy the current grantee is the pointer, so it drops to lowest priority on rescan.
  assign pick_ptr = (state_q == ST_BUSY) ? sel_q : last_q;

  rr_pick8 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  mux81 u_mux (
    .i (d),
    .s (sel_q),
    .y (mux_y)
  );

  // State register: FSM state, select, priority pointer and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant from idle, or on release hand over directly / fall back to idle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    release_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_BUSY;
          sel_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        release_now = done || !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD - 1));
        if (release_now) begin
          cnt_d = '0;
          if (pick_any) begin
            sel_d  = pick_idx;
            last_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs derived from registered state: grant is one-hot of sel only while busy.
  always_comb begin
    sel   = sel_q;
    valid = (state_q == ST_BUSY);
    gnt   = valid ? (N_REQ'(1) << sel_q) : '0;
    y     = valid & mux_y;
  end

endmodule

// File: tb/tb_mux81_rr_sched.sv
module tb_mux81_rr_sched;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] d;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid;
  logic       y;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who holds the grant and for how many cycles it has been visible
  bit m_busy;
  int m_sel;
  int m_last;
  int m_held;

  always #5 clk = ~clk;

  mux81_rr_sched #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .done  (done),
    .d     (d),
    .sel   (sel),
    .gnt   (gnt),
    .valid (valid),
    .y     (y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int ptr);
    for (int off = 1; off <= 8; off++) begin
      int j;
      j = (ptr + off) % 8;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input bit r, input logic [7:0] rq, input bit dn);
    int k;
    if (r) begin
      m_busy = 0; m_sel = 0; m_last = 7; m_held = 0;
    end else if (!m_busy) begin
      k = pick(rq, m_last);
      if (k >= 0) begin
        m_busy = 1; m_sel = k; m_last = k; m_held = 1;
      end
    end else if (dn || !rq[m_sel] || m_held >= MAXH) begin
      k = pick(rq, m_sel);
      if (k >= 0) begin
        m_sel = k; m_last = k; m_held = 1;
      end else begin
        m_busy = 0; m_held = 0;
      end
    end else begin
      m_held++;
    end
  endtask

  // apply inputs for one cycle, advance the model at the edge, compare just after it
  task automatic step(input bit r, input logic [7:0] rq, input bit dn, input logic [7:0] dd);
    logic [7:0] eg;
    rst = r; req = rq; done = dn; d = dd;
    @(posedge clk);
    model_edge(r, rq, dn);
    #1;
    eg = m_busy ? (8'd1 << m_sel) : 8'd0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("valid", 32'(valid), 32'(m_busy));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("y", 32'(y), 32'(m_busy & dd[m_sel]));
  endtask

  initial begin
    logic [7:0] rr;
    rst = 1'b1; req = '0; done = 1'b0; d = '0;
    m_busy = 0; m_sel = 0; m_last = 7; m_held = 0;
    #2;

    // reset and single request
    step(1, 8'h00, 0, 8'h00);
    step(1, 8'h00, 0, 8'h00);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    step(0, 8'h04, 0, 8'h04);
    chk("single_gnt", 32'(gnt), 32'h04);
    chk("single_sel", 32'(sel), 32'd2);
    chk("single_y1", 32'(y), 32'd1);
    step(0, 8'h04, 0, 8'h00);
    chk("single_y0", 32'(y), 32'd0);

    // fairness: everyone requests, done every cycle
    step(1, 8'h00, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(0, 8'hFF, 1, 8'hAA);
      chk("rr_sel", 32'(sel), 32'(i % 8));
      chk("rr_valid", 32'(valid), 32'd1);
    end

    // timeout rotation between two requesters
    step(1, 8'h00, 0, 8'h00);
    for (int i = 0; i < 48; i++) begin
      step(0, 8'h03, 0, 8'h01);
      chk("to_gnt", 32'(gnt), ((i / 16) % 2 == 0) ? 32'h01 : 32'h02);
    end

    // release to idle, then pointer-based rescan
    step(1, 8'h00, 0, 8'h00);
    step(0, 8'h20, 0, 8'hFF);
    chk("idle_pre_gnt", 32'(gnt), 32'h20);
    step(0, 8'h00, 0, 8'hFF);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);
    chk("idle_y", 32'(y), 32'h0);
    chk("idle_sel", 32'(sel), 32'd5);
    step(0, 8'h21, 0, 8'hFF);
    chk("idle_wrap_gnt", 32'(gnt), 32'h01);

    // reset mid-grant
    step(1, 8'h00, 0, 8'h00);
    step(0, 8'h10, 0, 8'h10);
    chk("mid_pre_gnt", 32'(gnt), 32'h10);
    step(1, 8'h10, 0, 8'h10);
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_sel", 32'(sel), 32'd0);
    chk("mid_valid", 32'(valid), 32'd0);
    step(0, 8'h81, 0, 8'h00);
    chk("mid_after_gnt", 32'(gnt), 32'h01);

    // stray done while idle
    step(1, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 8'hFF);
      chk("stray_gnt", 32'(gnt), 32'h0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 3) == 0) rr = 8'($urandom);
      step(($urandom_range(0, 99) == 0), rr, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
